// File: rtl/apb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and constants for the APB master arbiter.
//               FSM state encoding, slave-select field width, slave count
//               and a one-hot select decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

  localparam int c_SEL_W   = 2;
  localparam int c_NUM_SLV = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // One-hot slave select from the address select field.
  function automatic logic [c_NUM_SLV-1:0] sel_decode(input logic [c_SEL_W-1:0] sel);
    logic [c_NUM_SLV-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter_if
// Description : Requester-side and APB-side signal bundle of the arbiter.
//               master modport : view of the arbiter itself
//               slave modport  : view of the surrounding requesters/fabric
//   req_i/addr_i/write_i/wdata_i : packed per-requester transfer requests
//   gnt_o/done_o/rdata_o/err_o   : grant, completion pulse and response
//   psel_o..pwdata_o             : APB master outputs
//   prdata_i/pready_i/pslverr_i  : APB slave responses
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*32-1:0] addr_i;
  logic [NUM_REQ-1:0]    write_i;
  logic [NUM_REQ*32-1:0] wdata_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    done_o;
  logic [31:0]           rdata_o;
  logic                  err_o;
  logic [c_NUM_SLV-1:0]  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [31:0]           paddr_o;
  logic [31:0]           pwdata_o;
  logic [31:0]           prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    input  req_i, addr_i, write_i, wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o,
           paddr_o, pwdata_o
  );

  modport slave (
    output req_i, addr_i, write_i, wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o,
           paddr_o, pwdata_o
  );

endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin picker. Search starts at
//               (i_last_gnt+1) mod NUM_REQ and ascends with wrap-around.
//   i_eligible : requests allowed to win this cycle
//   i_last_gnt : index of the previous winner
//   o_gnt_oh   : one-hot winner
//   o_gnt_idx  : encoded winner
//   o_gnt_vld  : any requester won
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_vld
);

  always_comb begin
    int cand;
    cand      = 0;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(i_last_gnt) + 1 + k) % NUM_REQ;
      if (!o_gnt_vld && i_eligible[cand]) begin
        o_gnt_vld      = 1'b1;
        o_gnt_idx      = IDX_W'(cand);
        o_gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Shares one APB master port between NUM_REQ requesters with
//               round-robin grants. Each grant runs SETUP then ACCESS, the
//               slave select is decoded from addr[SEL_LSB+1:SEL_LSB] and the
//               response is returned with a one-cycle done pulse.
//   pclk    : clock, rising edge
//   presetn : asynchronous active-low reset
//   bus     : apb_master_arbiter_if.master (requester and APB signals)
// Optional    : APB_ARB_TIMEOUT_EN adds an ACCESS wait limit of
//               TIMEOUT_CYCLES consecutive pready_i-low cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  apb_master_arbiter_if.master      bus
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e           r_state;
  apb_state_e           w_state_nxt;
  logic [c_IDX_W-1:0]   r_last_gnt;
  logic [c_IDX_W-1:0]   w_win_idx;
  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_win_vld;
  logic                 w_start;
  logic                 w_complete;
  logic                 w_timeout;
  logic [31:0]          w_win_addr;
  logic [31:0]          w_win_wdata;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [c_NUM_SLV-1:0] r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [31:0]          r_paddr;
  logic [31:0]          r_pwdata;

  // A requester is blind during its own done cycle so it can drop req
  // on the next cycle without being granted a second time.
  assign w_eligible = bus.req_i & ~r_done;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr (
    .i_eligible (w_eligible),
    .i_last_gnt (r_last_gnt),
    .o_gnt_oh   (w_win_oh),
    .o_gnt_idx  (w_win_idx),
    .o_gnt_vld  (w_win_vld)
  );

  assign w_win_addr  = bus.addr_i[32*int'(w_win_idx) +: 32];
  assign w_win_wdata = bus.wdata_i[32*int'(w_win_idx) +: 32];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_wait_cnt;

  // Counts pready_i-low ACCESS cycles; cleared while in SETUP so every
  // ACCESS phase starts from zero.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_ACCESS && !bus.pready_i) begin
      r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive low cycle.
  assign w_timeout = (r_state == ST_ACCESS) && !bus.pready_i &&
                     (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No wait limit in this build; constant 0 for any legal TIMEOUT_CYCLES.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_SETUP;
          w_start     = 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready_i || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_complete  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last_gnt <= c_IDX_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
    end else begin
      // Response fields are only meaningful alongside done; zero otherwise.
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;

      if (w_start) begin
        r_last_gnt <= w_win_idx;
        r_gnt      <= w_win_oh;
        r_paddr    <= w_win_addr;
        r_pwrite   <= bus.write_i[w_win_idx];
        r_pwdata   <= w_win_wdata;
        r_psel     <= sel_decode(w_win_addr[SEL_LSB +: c_SEL_W]);
      end

      if (r_state == ST_SETUP) begin
        r_penable <= 1'b1;
      end

      if (w_complete) begin
        r_done    <= r_gnt;
        r_gnt     <= '0;
        r_psel    <= '0;
        r_penable <= 1'b0;
        // A timeout completes with pready_i low: forced error, no data.
        r_err     <= bus.pready_i ? bus.pslverr_i : 1'b1;
        r_rdata   <= (bus.pready_i && !r_pwrite) ? bus.prdata_i : 32'h0;
      end
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.done_o    = r_done;
  assign bus.rdata_o   = r_rdata;
  assign bus.err_o     = r_err;
  assign bus.psel_o    = r_psel;
  assign bus.penable_o = r_penable;
  assign bus.pwrite_o  = r_pwrite;
  assign bus.paddr_o   = r_paddr;
  assign bus.pwdata_o  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Self-checking bench for apb_master_arbiter: directed vector
//               table, reset/round-robin and wait-limit sequences, then
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

  localparam int NR = 3;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  apb_master_arbiter_if #(.NUM_REQ(NR)) bus ();

  apb_master_arbiter #(
    .NUM_REQ        (NR),
    .SEL_LSB        (12),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rq;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [3:0]  exp_psel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur within its cycle budget", nm);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".psel"},    32'(bus.psel_o),    32'h0);
    chk({tag, ".penable"}, 32'(bus.penable_o), 32'h0);
    chk({tag, ".pwrite"},  32'(bus.pwrite_o),  32'h0);
    chk({tag, ".paddr"},   bus.paddr_o,        32'h0);
    chk({tag, ".pwdata"},  bus.pwdata_o,       32'h0);
    chk({tag, ".rdata"},   bus.rdata_o,        32'h0);
    chk({tag, ".err"},     32'(bus.err_o),     32'h0);
    chk({tag, ".gnt"},     32'(bus.gnt_o),     32'h0);
    chk({tag, ".done"},    32'(bus.done_o),    32'h0);
  endtask

  // One isolated transfer from a single requester, slave inserts v.waits
  // low-pready cycles in ACCESS.
  task automatic run_vec(input int id, input vec_t v);
    int n, sel_cyc, en_cyc, acc, done_at;
    @(negedge pclk);
    bus.req_i = '0;
    bus.req_i[v.rq] = 1'b1;
    bus.addr_i[32*v.rq +: 32]  = v.addr;
    bus.write_i[v.rq]          = v.wr;
    bus.wdata_i[32*v.rq +: 32] = v.wdata;
    bus.prdata_i  = v.prdata;
    bus.pslverr_i = v.slverr;
    bus.pready_i  = 1'b0;
    n = 0; sel_cyc = 0; en_cyc = 0; acc = 0; done_at = -1;
    while (done_at < 0 && n < 40) begin
      @(negedge pclk);
      n++;
      if (bus.psel_o != 0) begin
        sel_cyc++;
        if (sel_cyc == 1) begin
          chk($sformatf("vec%0d.psel", id),    32'(bus.psel_o),    32'(v.exp_psel));
          chk($sformatf("vec%0d.gnt", id),     32'(bus.gnt_o),     32'(1 << v.rq));
          chk($sformatf("vec%0d.penable_setup", id), 32'(bus.penable_o), 32'h0);
          chk($sformatf("vec%0d.paddr", id),   bus.paddr_o,        v.addr);
          chk($sformatf("vec%0d.pwrite", id),  32'(bus.pwrite_o),  32'(v.wr));
          chk($sformatf("vec%0d.pwdata", id),  bus.pwdata_o,       v.wdata);
        end
      end
      if (bus.penable_o) en_cyc++;
      if (bus.done_o != 0) begin
        done_at = n;
        chk($sformatf("vec%0d.done", id),  32'(bus.done_o), 32'(1 << v.rq));
        chk($sformatf("vec%0d.rdata", id), bus.rdata_o,     v.exp_rdata);
        chk($sformatf("vec%0d.err", id),   32'(bus.err_o),  32'(v.exp_err));
        chk($sformatf("vec%0d.gnt_at_done", id), 32'(bus.gnt_o), 32'h0);
        bus.req_i = '0;
      end
      bus.pready_i = bus.penable_o && (acc >= v.waits);
      if (bus.penable_o) acc++;
    end
    if (done_at < 0) begin
      fail_now($sformatf("vec%0d.done_seen", id));
      bus.req_i = '0;
    end else begin
      chk($sformatf("vec%0d.latency", id),    32'(done_at), 32'(v.exp_lat));
      chk($sformatf("vec%0d.psel_cycles", id), 32'(sel_cyc), 32'(v.exp_lat - 1));
      chk($sformatf("vec%0d.access_cycles", id), 32'(en_cyc), 32'(v.waits + 1));
    end
    bus.pready_i = 1'b0;
    @(negedge pclk);
    chk($sformatf("vec%0d.done_after", id), 32'(bus.done_o), 32'h0);
    chk($sformatf("vec%0d.no_regrant", id), 32'(bus.psel_o), 32'h0);
  endtask

  // Reset in the middle of ACCESS, then all three requesters held for six
  // transfers: order must restart at requester 0 and rotate.
  task automatic run_reset_rr();
    int n, cnt, last_at, idx;
    bit got;
    @(negedge pclk);
    for (int i = 0; i < NR; i++) begin
      bus.addr_i[32*i +: 32]  = 32'(i) << 12;
      bus.wdata_i[32*i +: 32] = 32'h100 + 32'(i);
    end
    bus.write_i  = '1;
    bus.req_i    = '1;
    bus.pready_i = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge pclk);
      n++;
      if (bus.penable_o) got = 1'b1;
    end
    if (!got) fail_now("rst_mid.reach_access");
    #2 presetn = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge pclk);
    check_zero("rst_low");
    presetn      = 1'b1;
    bus.pready_i = 1'b1;
    cnt = 0; n = 0; last_at = 0;
    while (cnt < 6 && n < 60) begin
      @(negedge pclk);
      n++;
      if (n == 1) begin
        chk("rr.first_gnt", 32'(bus.gnt_o), 32'h1);
        chk("rr.no_done_after_rst", 32'(bus.done_o), 32'h0);
      end
      if (bus.done_o != 0) begin
        idx = -1;
        for (int k = 0; k < NR; k++) if (bus.done_o[k]) idx = k;
        chk("rr.done_onehot", 32'($countones(bus.done_o)), 32'h1);
        chk($sformatf("rr.order%0d", cnt), 32'(idx), 32'(cnt % 3));
        if (cnt > 0) chk($sformatf("rr.spacing%0d", cnt), 32'(n - last_at), 32'h3);
        last_at = n;
        cnt++;
        if (cnt == 6) bus.req_i = '0;
      end
    end
    if (cnt < 6) begin
      fail_now("rr.six_transfers");
      bus.req_i = '0;
    end
    bus.pready_i = 1'b0;
    @(negedge pclk);
    chk("rr.idle_after", 32'(bus.psel_o), 32'h0);
  endtask

  task automatic run_timeout();
    int n, acc;
    bit seen_done;
    @(negedge pclk);
    bus.req_i                = 3'b001;
    bus.addr_i[31:0]         = 32'h0000_0040;
    bus.write_i              = '0;
    bus.prdata_i             = 32'hFFFF_FFFF;
    bus.pslverr_i            = 1'b0;
    bus.pready_i             = 1'b0;
    n = 0; acc = 0; seen_done = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    while (!seen_done && n < 100) begin
      @(negedge pclk);
      n++;
      if (bus.penable_o) acc++;
      if (bus.done_o != 0) begin
        seen_done = 1'b1;
        bus.req_i = '0;
        chk("to.done",  32'(bus.done_o), 32'h1);
        chk("to.err",   32'(bus.err_o),  32'h1);
        chk("to.rdata", bus.rdata_o,     32'h0);
      end
    end
    if (!seen_done) fail_now("to.done_seen");
    else chk("to.access_cycles", 32'(acc), 32'd16);
    bus.req_i = '0;
`else
    repeat (40) begin
      @(negedge pclk);
      if (bus.penable_o) acc++;
      if (bus.done_o != 0) seen_done = 1'b1;
    end
    chk("to.still_access",  32'(bus.penable_o), 32'h1);
    chk("to.no_done",       32'(seen_done),     32'h0);
    chk("to.access_cycles", 32'(acc),           32'd39);
    bus.pready_i = 1'b1;
    while (!seen_done && n < 10) begin
      @(negedge pclk);
      n++;
      if (bus.done_o != 0) begin
        seen_done = 1'b1;
        bus.req_i = '0;
        chk("to.late_done",  32'(bus.done_o), 32'h1);
        chk("to.late_err",   32'(bus.err_o),  32'h0);
        chk("to.late_rdata", bus.rdata_o,     32'hFFFF_FFFF);
      end
    end
    if (!seen_done) fail_now("to.late_done_seen");
    bus.req_i    = '0;
    bus.pready_i = 1'b0;
`endif
    @(negedge pclk);
  endtask

  // Transaction-level model: pending requests per requester, a rotating
  // winner pointer, and the APB rule that a transfer ends one edge after
  // an ACCESS cycle with pready high.
  logic [31:0] m_addr[NR];
  logic        m_wr[NR];
  logic [31:0] m_wdata[NR];

  task automatic new_txn(input int i);
    m_addr[i]  = $urandom;
    m_wr[i]    = 1'($urandom % 2);
    m_wdata[i] = $urandom;
    bus.addr_i[32*i +: 32]  = m_addr[i];
    bus.write_i[i]          = m_wr[i];
    bus.wdata_i[32*i +: 32] = m_wdata[i];
    bus.req_i[i]            = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    logic [NR-1:0] p_req, p_done, p_gnt, elig;
    logic [3:0]    p_psel;
    logic          p_pen, p_pready, p_slverr, p_pwrite;
    logic [31:0]   p_prdata, p_paddr;
    logic          exp_done, exp_start, started;
    int last_w, cur_w, wait_run, j, s;
    last_w = NR - 1; cur_w = 0; wait_run = 0;
    p_req = '0; p_done = '0; p_gnt = '0; p_psel = '0;
    p_pen = 1'b0; p_pready = 1'b0; p_slverr = 1'b0; p_pwrite = 1'b0;
    p_prdata = '0; p_paddr = '0;
    bus.req_i = '0; bus.pready_i = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge pclk);
      exp_done = p_pen && p_pready;
      if (exp_done) begin
        chk("rnd.done",  32'(bus.done_o), 32'(1 << cur_w));
        chk("rnd.err",   32'(bus.err_o),  32'(p_slverr));
        chk("rnd.rdata", bus.rdata_o,     p_pwrite ? 32'h0 : p_prdata);
        chk("rnd.gnt_clear", 32'(bus.gnt_o), 32'h0);
        chk("rnd.psel_clear", 32'(bus.psel_o), 32'h0);
      end else begin
        chk("rnd.no_done", 32'(bus.done_o), 32'h0);
      end
      elig      = p_req & ~p_done;
      exp_start = (p_psel == 0) && (elig != 0);
      started   = (p_psel == 0) && (bus.psel_o != 0);
      chk("rnd.start", 32'(started), 32'(exp_start));
      if (exp_start) begin
        j = -1;
        for (int k = 1; k <= NR; k++)
          if (j < 0 && elig[(last_w + k) % NR]) j = (last_w + k) % NR;
        last_w = j;
        cur_w  = j;
        s = int'(m_addr[j][13:12]);
        chk("rnd.gnt",     32'(bus.gnt_o),     32'(1 << j));
        chk("rnd.psel",    32'(bus.psel_o),    32'(1 << s));
        chk("rnd.paddr",   bus.paddr_o,        m_addr[j]);
        chk("rnd.pwrite",  32'(bus.pwrite_o),  32'(m_wr[j]));
        chk("rnd.pwdata",  bus.pwdata_o,       m_wdata[j]);
        chk("rnd.setup_penable", 32'(bus.penable_o), 32'h0);
      end
      if (p_psel != 0 && !exp_done) begin
        chk("rnd.hold_psel",  32'(bus.psel_o),    32'(p_psel));
        chk("rnd.hold_gnt",   32'(bus.gnt_o),     32'(p_gnt));
        chk("rnd.hold_paddr", bus.paddr_o,        p_paddr);
        chk("rnd.access",     32'(bus.penable_o), 32'h1);
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.done_o[i]) begin
          if ($urandom % 2 == 0) new_txn(i);
          else bus.req_i[i] = 1'b0;
        end else if (!bus.req_i[i] && ($urandom % 3 == 0)) begin
          new_txn(i);
        end
      end
      bus.prdata_i  = $urandom;
      bus.pslverr_i = ($urandom % 4 == 0);
      if (bus.penable_o) begin
        if (wait_run >= 4 || ($urandom % 2 == 0)) begin
          bus.pready_i = 1'b1;
          wait_run = 0;
        end else begin
          bus.pready_i = 1'b0;
          wait_run++;
        end
      end else begin
        bus.pready_i = 1'($urandom % 2);
        wait_run = 0;
      end
      p_req = bus.req_i;   p_done = bus.done_o;  p_gnt = bus.gnt_o;
      p_psel = bus.psel_o; p_pen = bus.penable_o; p_pready = bus.pready_i;
      p_slverr = bus.pslverr_i; p_prdata = bus.prdata_i;
      p_pwrite = bus.pwrite_o;  p_paddr = bus.paddr_o;
    end
    bus.req_i = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i     = '0;
    bus.addr_i    = '0;
    bus.write_i   = '0;
    bus.wdata_i   = '0;
    bus.prdata_i  = '0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;

    vecs[0] = '{0, 32'h0000_1004, 1'b1, 32'hA5A5_0001, 0, 32'h1111_1111, 1'b0,
                4'b0010, 32'h0000_0000, 1'b0, 3};
    vecs[1] = '{2, 32'h0000_3010, 1'b0, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0,
                4'b1000, 32'hDEAD_BEEF, 1'b0, 6};
    vecs[2] = '{1, 32'h0000_2000, 1'b1, 32'h0000_CAFE, 0, 32'h2222_2222, 1'b1,
                4'b0100, 32'h0000_0000, 1'b1, 3};
    vecs[3] = '{1, 32'h0000_0ABC, 1'b0, 32'h0000_0000, 0, 32'h1234_5678, 1'b0,
                4'b0001, 32'h1234_5678, 1'b0, 3};
    vecs[4] = '{0, 32'h1FFF_F000, 1'b0, 32'h0000_0000, 1, 32'h0BAD_F00D, 1'b1,
                4'b1000, 32'h0BAD_F00D, 1'b1, 4};

    #1 check_zero("rst_async");
    repeat (2) @(negedge pclk);
    check_zero("rst_hold");
    presetn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    run_reset_rr();
    run_timeout();

    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    run_random(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between NUM_REQ on-chip requesters. Each granted request becomes a full APB transfer (SETUP then ACCESS, extended by `pready_i`). Grants rotate round-robin. The block decodes one of four slave selects from the address and returns read data and error status to the winning requester. It sits between the bus-bridge front ends and the APB peripheral fabric.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- SEL_LSB, 12, lowest address bit of the 2-bit slave-select field
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with `pready_i` low (used only with the timeout feature)
- pclk  in  1  clock; all logic on rising edge
- presetn  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ  per-requester request, held until its done pulse
- addr_i  in  NUM_REQ*32  packed addresses, requester i at [32*i+31:32*i]
- write_i  in  NUM_REQ  per-requester write flag
- wdata_i  in  NUM_REQ*32  packed write data
- gnt_o  out  NUM_REQ  one-hot, high from SETUP through the final ACCESS cycle
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata_o  out  32  read data, valid while any done_o bit is high
- err_o  out  1  transfer error, valid while any done_o bit is high
- psel_o  out  4  one-hot APB slave select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  32  APB address
- pwdata_o  out  32  APB write data
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- FSM states:
  - IDLE: all selects and penable low; arbitrate.
  - SETUP: psel_o set, penable_o=0.
  - ACCESS: penable_o=1.
- Transitions:
  - IDLE→SETUP when any request is eligible.
  - SETUP→ACCESS always.
  - ACCESS→IDLE on `pready_i` (or on timeout).
  - Reaching IDLE always costs one cycle between transfers.
- Eligible request: `req_i[i] & ~done_o[i]`. A requester's request is ignored in the cycle its done pulse is high, so it can drop req the cycle after done without being re-granted.
- Round-robin:
  - Priority starts at (last_gnt+1) mod NUM_REQ and ascends with wrap.
  - last_gnt resets to NUM_REQ-1, so requester 0 wins first.
  - last_gnt updates on the IDLE→SETUP edge.
- On the grant edge, register the winner's addr, write and wdata into paddr_o, pwrite_o and pwdata_o. These stay stable through ACCESS.
- psel_o is one-hot at bit `addr[SEL_LSB+1:SEL_LSB]`.
- Completion (ACCESS with `pready_i`=1):
  - done_o[g] pulses.
  - err_o = pslverr_i.
  - rdata_o = prdata_i for reads, 0 for writes.
  - All three are registered; they are valid in the first IDLE cycle.
- Reset mid-transfer: all outputs clear immediately and the FSM returns to IDLE. The interrupted requester gets no done pulse and must re-request.

## Timing
- Reset value of every output is 0. This includes psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rdata_o, err_o, gnt_o and done_o.
- Request seen at edge k gives SETUP in cycle k+1 and ACCESS in cycle k+2.
- With zero wait states, done is high in cycle k+3.
- Each low `pready_i` cycle adds one cycle.
- Back-to-back throughput is one transfer per 3 cycles at zero wait states.
- gnt_o deasserts in the same cycle done_o asserts.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An ACCESS wait counter aborts the transfer after TIMEOUT_CYCLES consecutive cycles with `pready_i` low.
  - On abort: done_o[g] pulses, err_o=1, rdata_o=0, FSM goes to IDLE.
  - The counter clears on entering ACCESS.
- Not defined: no counter; ACCESS waits on `pready_i` indefinitely; TIMEOUT_CYCLES is ignored.

## Structure
- Package `apb_arb_pkg`: FSM state enum (IDLE, SETUP, ACCESS), slave-select width constant (2), and number of slaves (4).
- Sub-module `apb_rr_arbiter`:
  - Inputs: eligible vector, last_gnt pointer.
  - Outputs: one-hot grant and encoded index (combinational).
  - Pointer register stays in the top level.

## Test plan
- Single write, requester 0, addr 0x0000_1004, wdata 0xA5A5_0001, pready_i tied high → psel_o=4'b0010 for 2 cycles, penable_o high 1 cycle, done_o[0] in cycle 3, err_o=0.
- Read from requester 2 with 3 wait states, prdata_i=0xDEAD_BEEF → ACCESS lasts 4 cycles, rdata_o=0xDEAD_BEEF with done_o[2].
- All three requesters held high for 6 transfers → grant order 0,1,2,0,1,2; no requester re-granted in its done cycle.
- pslverr_i=1 on a write → err_o=1 with done; next transfer has err_o=0.
- presetn pulsed low during ACCESS → all outputs 0 asynchronously, no done pulse; after release, requester 0 wins first.
- Timeout, with the macro defined and pready_i held low → done with err_o=1 after exactly 16 ACCESS cycles. Without the macro, the block stays in ACCESS.
